// File: rtl/rob_complete.sv
// rob_complete: 16-entry reorder buffer. Captures three FU result buses,
// forwards them to dispatch and retires up to two entries per cycle in order.
module rob_complete #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_en_1,
    input  logic              alloc_en_2,
    input  logic [PREG_W-1:0] alloc_pd_1,
    input  logic [PREG_W-1:0] alloc_pd_2,
    input  logic [PREG_W-1:0] alloc_old_pd_1,
    input  logic [PREG_W-1:0] alloc_old_pd_2,
    input  logic [6:0]        alloc_op_1,
    input  logic [6:0]        alloc_op_2,
    output logic              alloc_ready,
    output logic [3:0]        alloc_idx_1,
    output logic [3:0]        alloc_idx_2,
    input  logic              result_valid_1,
    input  logic              result_valid_2,
    input  logic              result_valid_3,
    input  logic [3:0]        result_rob_1,
    input  logic [3:0]        result_rob_2,
    input  logic [3:0]        result_rob_3,
    input  logic [PREG_W-1:0] result_dest_1,
    input  logic [PREG_W-1:0] result_dest_2,
    input  logic [PREG_W-1:0] result_dest_3,
    input  logic [DATA_W-1:0] result_1,
    input  logic [DATA_W-1:0] result_2,
    input  logic [DATA_W-1:0] result_3,
    output logic              f_flag_1,
    output logic              f_flag_2,
    output logic              f_flag_3,
    output logic [PREG_W-1:0] dest_r_1,
    output logic [PREG_W-1:0] dest_r_2,
    output logic [PREG_W-1:0] dest_r_3,
    output logic [DATA_W-1:0] f_data_1,
    output logic [DATA_W-1:0] f_data_2,
    output logic [DATA_W-1:0] f_data_3,
    output logic              retire_valid_1,
    output logic              retire_valid_2,
    output logic [PREG_W-1:0] retire_pd_1,
    output logic [PREG_W-1:0] retire_pd_2,
    output logic [PREG_W-1:0] retire_old_pd_1,
    output logic [PREG_W-1:0] retire_old_pd_2,
    output logic [DATA_W-1:0] retire_data_1,
    output logic [DATA_W-1:0] retire_data_2,
    output logic [4:0]        rob_count
);
    localparam int IW = 4;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [IW:0] READY_MAX = 5'(DEPTH - 2);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [PREG_W-1:0] pd_q     [DEPTH];
    logic [PREG_W-1:0] old_pd_q [DEPTH];
    logic [6:0]        op_q     [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];

    logic [IW-1:0] head_q;
    logic [IW-1:0] tail_q;
    logic [IW:0]   count_q;
    logic [IW-1:0] head_p1;
    logic [IW-1:0] tail_p1;

    logic          do_a1;
    logic          do_a2;
    logic          ret_1;
    logic          ret_2;
    logic [1:0]    n_alloc;
    logic [1:0]    n_ret;

    logic              res_v   [3];
    logic [IW-1:0]     res_rob [3];
    logic [PREG_W-1:0] res_dst [3];
    logic [DATA_W-1:0] res_dat [3];
    logic              res_acc [3];

    logic              fwd_flag_q [3];
    logic [PREG_W-1:0] fwd_dst_q  [3];
    logic [DATA_W-1:0] fwd_dat_q  [3];

    assign res_v[0]   = result_valid_1;
    assign res_v[1]   = result_valid_2;
    assign res_v[2]   = result_valid_3;
    assign res_rob[0] = result_rob_1;
    assign res_rob[1] = result_rob_2;
    assign res_rob[2] = result_rob_3;
    assign res_dst[0] = result_dest_1;
    assign res_dst[1] = result_dest_2;
    assign res_dst[2] = result_dest_3;
    assign res_dat[0] = result_1;
    assign res_dat[1] = result_2;
    assign res_dat[2] = result_3;

    assign head_p1 = head_q + 4'd1;
    assign tail_p1 = tail_q + 4'd1;

    // Two slots stay reserved so a dual allocation never overruns head.
    assign alloc_ready = (count_q <= READY_MAX);
    assign alloc_idx_1 = tail_q;
    assign alloc_idx_2 = alloc_en_1 ? tail_p1 : tail_q;

    assign do_a1   = alloc_ready && alloc_en_1;
    assign do_a2   = do_a1 && alloc_en_2;
    assign n_alloc = 2'(do_a1) + 2'(do_a2);

    assign ret_1 = valid_q[head_q] && done_q[head_q];
    assign ret_2 = ret_1 && valid_q[head_p1] && done_q[head_p1];
    assign n_ret = 2'(ret_1) + 2'(ret_2);

    // Lower-numbered FU wins when two buses name the same entry.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            res_acc[k] = res_v[k] && valid_q[res_rob[k]]
                         && !done_q[res_rob[k]];
            for (int j = 0; j < k; j++) begin
                if (res_v[j] && (res_rob[j] == res_rob[k])) begin
                    res_acc[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pd_q[i]     <= '0;
                old_pd_q[i] <= '0;
                op_q[i]     <= '0;
                data_q[i]   <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (res_acc[k]) begin
                    done_q[res_rob[k]] <= 1'b1;
                    data_q[res_rob[k]] <= res_dat[k];
                end
            end
            if (ret_1) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
            if (ret_2) begin
                valid_q[head_p1] <= 1'b0;
                done_q[head_p1]  <= 1'b0;
            end
            if (do_a1) begin
                valid_q[tail_q]  <= 1'b1;
                done_q[tail_q]   <= 1'b0;
                pd_q[tail_q]     <= alloc_pd_1;
                old_pd_q[tail_q] <= alloc_old_pd_1;
                op_q[tail_q]     <= alloc_op_1;
            end
            if (do_a2) begin
                valid_q[tail_p1]  <= 1'b1;
                done_q[tail_p1]   <= 1'b0;
                pd_q[tail_p1]     <= alloc_pd_2;
                old_pd_q[tail_p1] <= alloc_old_pd_2;
                op_q[tail_p1]     <= alloc_op_2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + 4'(n_ret);
            tail_q  <= tail_q + 4'(n_alloc);
            count_q <= count_q + 5'(n_alloc) - 5'(n_ret);
        end
    end

    // Stores complete but have no register result to wake consumers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                fwd_flag_q[k] <= 1'b0;
                fwd_dst_q[k]  <= '0;
                fwd_dat_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                fwd_flag_q[k] <= res_acc[k] && (op_q[res_rob[k]] != OP_SW);
                if (res_acc[k]) begin
                    fwd_dst_q[k] <= res_dst[k];
                    fwd_dat_q[k] <= res_dat[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_valid_1  <= 1'b0;
            retire_valid_2  <= 1'b0;
            retire_pd_1     <= '0;
            retire_pd_2     <= '0;
            retire_old_pd_1 <= '0;
            retire_old_pd_2 <= '0;
            retire_data_1   <= '0;
            retire_data_2   <= '0;
        end else begin
            retire_valid_1  <= ret_1;
            retire_valid_2  <= ret_2;
            retire_pd_1     <= ret_1 ? pd_q[head_q] : '0;
            retire_pd_2     <= ret_2 ? pd_q[head_p1] : '0;
            retire_old_pd_1 <= ret_1 ? old_pd_q[head_q] : '0;
            retire_old_pd_2 <= ret_2 ? old_pd_q[head_p1] : '0;
            retire_data_1   <= ret_1 ? data_q[head_q] : '0;
            retire_data_2   <= ret_2 ? data_q[head_p1] : '0;
        end
    end

    assign f_flag_1  = fwd_flag_q[0];
    assign f_flag_2  = fwd_flag_q[1];
    assign f_flag_3  = fwd_flag_q[2];
    assign dest_r_1  = fwd_dst_q[0];
    assign dest_r_2  = fwd_dst_q[1];
    assign dest_r_3  = fwd_dst_q[2];
    assign f_data_1  = fwd_dat_q[0];
    assign f_data_2  = fwd_dat_q[1];
    assign f_data_3  = fwd_dat_q[2];
    assign rob_count = count_q;

endmodule

// File: tb/tb_rob_complete.sv
// tb_rob_complete: directed checks for allocation, completion, forwarding,
// in-order retirement, full/wrap behaviour and asynchronous reset.
module tb_rob_complete;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_SW  = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_en_1, alloc_en_2;
    logic [5:0]  alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2;
    logic [6:0]  alloc_op_1, alloc_op_2;
    logic        alloc_ready;
    logic [3:0]  alloc_idx_1, alloc_idx_2;
    logic        result_valid_1, result_valid_2, result_valid_3;
    logic [3:0]  result_rob_1, result_rob_2, result_rob_3;
    logic [5:0]  result_dest_1, result_dest_2, result_dest_3;
    logic [31:0] result_1, result_2, result_3;
    logic        f_flag_1, f_flag_2, f_flag_3;
    logic [5:0]  dest_r_1, dest_r_2, dest_r_3;
    logic [31:0] f_data_1, f_data_2, f_data_3;
    logic        retire_valid_1, retire_valid_2;
    logic [5:0]  retire_pd_1, retire_pd_2;
    logic [5:0]  retire_old_pd_1, retire_old_pd_2;
    logic [31:0] retire_data_1, retire_data_2;
    logic [4:0]  rob_count;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int tl = 0;
    int seq = 0;

    always #5 clk = ~clk;

    rob_complete dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_en_1(alloc_en_1), .alloc_en_2(alloc_en_2),
        .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
        .alloc_old_pd_1(alloc_old_pd_1), .alloc_old_pd_2(alloc_old_pd_2),
        .alloc_op_1(alloc_op_1), .alloc_op_2(alloc_op_2),
        .alloc_ready(alloc_ready),
        .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
        .result_valid_1(result_valid_1), .result_valid_2(result_valid_2),
        .result_valid_3(result_valid_3),
        .result_rob_1(result_rob_1), .result_rob_2(result_rob_2),
        .result_rob_3(result_rob_3),
        .result_dest_1(result_dest_1), .result_dest_2(result_dest_2),
        .result_dest_3(result_dest_3),
        .result_1(result_1), .result_2(result_2), .result_3(result_3),
        .f_flag_1(f_flag_1), .f_flag_2(f_flag_2), .f_flag_3(f_flag_3),
        .dest_r_1(dest_r_1), .dest_r_2(dest_r_2), .dest_r_3(dest_r_3),
        .f_data_1(f_data_1), .f_data_2(f_data_2), .f_data_3(f_data_3),
        .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
        .retire_pd_1(retire_pd_1), .retire_pd_2(retire_pd_2),
        .retire_old_pd_1(retire_old_pd_1), .retire_old_pd_2(retire_old_pd_2),
        .retire_data_1(retire_data_1), .retire_data_2(retire_data_2),
        .rob_count(rob_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_en_1 = 1'b0;
        alloc_en_2 = 1'b0;
        result_valid_1 = 1'b0;
        result_valid_2 = 1'b0;
        result_valid_3 = 1'b0;
    endtask

    task automatic alloc(input logic e1, input logic e2,
                         input logic [5:0] p1, input logic [5:0] o1,
                         input logic [6:0] c1,
                         input logic [5:0] p2, input logic [5:0] o2,
                         input logic [6:0] c2);
        alloc_en_1 = e1; alloc_pd_1 = p1; alloc_old_pd_1 = o1; alloc_op_1 = c1;
        alloc_en_2 = e2; alloc_pd_2 = p2; alloc_old_pd_2 = o2; alloc_op_2 = c2;
    endtask

    task automatic res(input int k, input logic [3:0] r,
                       input logic [5:0] d, input logic [31:0] v);
        case (k)
            1: begin
                result_valid_1 = 1'b1; result_rob_1 = r;
                result_dest_1 = d; result_1 = v;
            end
            2: begin
                result_valid_2 = 1'b1; result_rob_2 = r;
                result_dest_2 = d; result_2 = v;
            end
            default: begin
                result_valid_3 = 1'b1; result_rob_3 = r;
                result_dest_3 = d; result_3 = v;
            end
        endcase
    endtask

    task automatic mon_slot(input logic v, input logic [5:0] o,
                            input logic [31:0] d);
        int s;
        if (v) begin
            if (exp_q.size() == 0) begin
                chk("wrap_extra_retire", 1, 0);
            end else begin
                s = exp_q.pop_front();
                chk("wrap_old_pd", o, 63 - s);
                chk("wrap_data", d, 32'hA000 + s);
            end
        end
    endtask

    task automatic tick_mon();
        tick();
        mon_slot(retire_valid_1, retire_old_pd_1, retire_data_1);
        mon_slot(retire_valid_2, retire_old_pd_2, retire_data_2);
    endtask

    initial begin
        idle();
        alloc(0, 0, 0, 0, 0, 0, 0, 0);
        res(1, 0, 0, 0); res(2, 0, 0, 0); res(3, 0, 0, 0);
        idle();
        #23 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_ready", alloc_ready, 1);
        chk("rst_count", rob_count, 0);
        chk("rst_fflag", {f_flag_1, f_flag_2, f_flag_3}, 0);
        chk("rst_retire", {retire_valid_1, retire_valid_2}, 0);
        chk("rst_idx1", alloc_idx_1, 0);
        chk("rst_idx2_noen", alloc_idx_2, 0);

        // Dual alloc, out-of-order completion, in-order dual retire
        alloc(1, 1, 10, 3, OP_ALU, 11, 4, OP_ALU);
        #1;
        chk("dual_idx1", alloc_idx_1, 0);
        chk("dual_idx2", alloc_idx_2, 1);
        tick();
        idle();
        res(2, 1, 11, 32'h22);
        tick();
        chk("t1_fflag2", f_flag_2, 1);
        chk("t1_dest2", dest_r_2, 11);
        chk("t1_data2", f_data_2, 32'h22);
        chk("t1_noret", retire_valid_1, 0);
        chk("t1_count", rob_count, 2);
        idle();
        res(1, 0, 10, 32'h11);
        tick();
        chk("t2_fflag1", f_flag_1, 1);
        chk("t2_dest1", dest_r_1, 10);
        chk("t2_fflag2_pulse", f_flag_2, 0);
        chk("t2_noret_head", retire_valid_1, 0);
        idle();
        tick();
        chk("t3_ret", {retire_valid_1, retire_valid_2}, 2'b11);
        chk("t3_pd1", retire_pd_1, 10);
        chk("t3_old1", retire_old_pd_1, 3);
        chk("t3_old2", retire_old_pd_2, 4);
        chk("t3_data1", retire_data_1, 32'h11);
        chk("t3_data2", retire_data_2, 32'h22);
        chk("t3_count", rob_count, 0);
        tl = 2;

        // Fill to 16 entries starting at index 2 (tail wraps 15->0)
        for (int n = 0; n < 7; n++) begin
            alloc(1, 1, 6'(20 + 2*n), 6'(40 + 2*n), OP_ALU,
                  6'(21 + 2*n), 6'(41 + 2*n), OP_ALU);
            tick();
        end
        chk("full_ready14", alloc_ready, 1);
        chk("full_count14", rob_count, 14);
        alloc(1, 1, 34, 54, OP_ALU, 35, 55, OP_ALU);
        tick();
        chk("full_count16", rob_count, 16);
        chk("full_ready16", alloc_ready, 0);
        alloc(1, 0, 1, 1, OP_ALU, 0, 0, OP_ALU);
        #1;
        chk("full_idx_wrap", alloc_idx_1, 2);
        tick();
        chk("full_drop", rob_count, 16);
        idle();
        res(1, 2, 20, 32'h100);
        tick();
        idle();
        tick();
        chk("full_ret_v", retire_valid_1, 1);
        chk("full_ret_old", retire_old_pd_1, 40);
        chk("full_count15", rob_count, 15);
        chk("full_ready15", alloc_ready, 0);
        res(2, 3, 21, 32'h101);
        tick();
        idle();
        tick();
        chk("full_ret_old2", retire_old_pd_1, 41);
        chk("full_count14b", rob_count, 14);
        chk("full_ready_back", alloc_ready, 1);
        for (int n = 2; n < 16; n++) begin
            idle();
            res((n % 3) + 1, 4'(2 + n), 6'(20 + n), 32'h100 + n);
            tick();
        end
        idle();
        for (int w = 0; w < 20 && rob_count != 0; w++) tick();
        chk("full_drained", rob_count, 0);

        // Wrap: 40 instructions, shuffled completion order per batch
        for (int b = 0; b < 5; b++) begin
            int idxs[8];
            int perm[8];
            int base;
            int j;
            int t;
            base = seq;
            for (int i = 0; i < 4; i++) begin
                alloc(1, 1, 6'(seq + 1), 6'(63 - seq), OP_ALU,
                      6'(seq + 2), 6'(62 - seq), OP_ALU);
                idxs[2*i] = tl;
                idxs[2*i+1] = (tl + 1) % 16;
                exp_q.push_back(seq);
                exp_q.push_back(seq + 1);
                tl = (tl + 2) % 16;
                seq += 2;
                tick_mon();
            end
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 8; i++) begin
                idle();
                res((i % 3) + 1, 4'(idxs[perm[i]]), 6'(base + perm[i] + 1),
                    32'hA000 + base + perm[i]);
                tick_mon();
            end
            idle();
            for (int w = 0; w < 12 && exp_q.size() > 0; w++) tick_mon();
            chk("wrap_left", exp_q.size(), 0);
        end
        chk("wrap_count", rob_count, 0);

        // SW, stale, duplicate and same-entry collision (tl = 10)
        alloc(1, 1, 7, 8, OP_SW, 9, 12, OP_ALU);
        tick();
        idle();
        res(3, 10, 7, 32'h55);
        res(1, 15, 33, 32'h99);
        tick();
        chk("sw_noflag", f_flag_3, 0);
        chk("stale_noflag", f_flag_1, 0);
        idle();
        res(2, 10, 7, 32'h66);
        res(1, 11, 9, 32'h77);
        res(3, 11, 9, 32'h88);
        tick();
        chk("dup_noflag", f_flag_2, 0);
        chk("coll_flag1", f_flag_1, 1);
        chk("coll_data1", f_data_1, 32'h77);
        chk("coll_dest1", dest_r_1, 9);
        chk("coll_noflag3", f_flag_3, 0);
        chk("sw_ret", {retire_valid_1, retire_valid_2}, 2'b10);
        chk("sw_ret_data", retire_data_1, 32'h55);
        chk("sw_ret_old", retire_old_pd_1, 8);
        idle();
        tick();
        chk("alu_ret_v", retire_valid_1, 1);
        chk("alu_ret_data", retire_data_1, 32'h77);
        chk("alu_ret_old", retire_old_pd_1, 12);
        chk("sw_count", rob_count, 0);

        // Async reset with 5 live entries (tl = 12)
        alloc(1, 1, 1, 2, OP_ALU, 3, 4, OP_ALU);
        tick();
        alloc(1, 1, 5, 6, OP_ALU, 7, 8, OP_ALU);
        tick();
        alloc(1, 0, 9, 10, OP_ALU, 0, 0, OP_ALU);
        res(1, 12, 1, 32'hAB);
        tick();
        idle();
        chk("ar_pre_flag", f_flag_1, 1);
        chk("ar_pre_count", rob_count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_flag", f_flag_1, 0);
        chk("ar_count", rob_count, 0);
        chk("ar_ready", alloc_ready, 1);
        chk("ar_ret", retire_valid_1, 0);
        chk("ar_idx", alloc_idx_1, 0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ar_post_ret", {retire_valid_1, retire_valid_2}, 0);
            chk("ar_post_count", rob_count, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
